// File: rtl/alu_link_master.sv
// Host-side initiator for the secure UART ALU link: password prefix, command bytes, result wait.
// Optional result timeout is built when ALU_LINK_MASTER_TIMEOUT_EN is defined.
module alu_link_master #(
    parameter logic [31:0] PASSWORD       = 32'h31323334,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [3:0] cmd_op,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_parity_err,
    output logic       res_timeout,
    output logic       authed,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_parity_error
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_GUARD = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    logic [2:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic [3:0] op_q, op_d;
    logic       authed_q, authed_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;
    logic       res_par_q, res_par_d;
    logic [7:0] cur_byte;

    // Password bytes, MSB first on the wire.
    logic [7:0] pw_bytes [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_pw
        assign pw_bytes[gi] = PASSWORD[31-8*gi -: 8];
    end

    always_comb begin
        cur_byte = pw_bytes[idx_q[1:0]];
        if (idx_q[2]) begin
            case (idx_q[1:0])
                2'd0:    cur_byte = a_q;
                2'd1:    cur_byte = b_q;
                default: cur_byte = {4'h0, op_q};
            endcase
        end
    end

`ifdef ALU_LINK_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_timeout_q, res_timeout_d;
    assign res_timeout = res_timeout_q;
`else
    assign res_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        authed_d    = authed_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_par_d   = res_par_q;
`ifdef ALU_LINK_MASTER_TIMEOUT_EN
        cnt_d         = cnt_q;
        res_timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    op_d    = cmd_op;
                    idx_d   = authed_q ? 3'd4 : 3'd0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!tx_busy) begin
                    tx_data_d  = cur_byte;
                    tx_start_d = 1'b1;
                    state_d    = ST_GUARD;
                end
            end
            // uart_tx raises busy a cycle late, so do not look at it here.
            ST_GUARD: state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!tx_busy) begin
                    if (idx_q == 3'd3) begin
                        authed_d = 1'b1;
                    end
                    if (idx_q == 3'd6) begin
                        state_d = ST_WAIT;
`ifdef ALU_LINK_MASTER_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (rx_valid) begin
                    res_data_d  = rx_data;
                    res_par_d   = rx_parity_error;
                    res_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
`ifdef ALU_LINK_MASTER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    res_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            authed_q    <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_par_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            authed_q    <= authed_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_par_q   <= res_par_d;
        end
    end

`ifdef ALU_LINK_MASTER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            res_timeout_q <= res_timeout_d;
        end
    end
`endif

    assign cmd_ready      = (state_q == ST_IDLE);
    assign authed         = authed_q;
    assign tx_data        = tx_data_q;
    assign tx_start       = tx_start_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_parity_err = res_par_q;

endmodule

// File: tb/tb_alu_link_master.sv
// Self-checking bench for alu_link_master: uart_tx busy model, byte monitor and expected-sequence model.
module tb_alu_link_master;

    localparam int          TO = 20;
    localparam logic [31:0] PW = 32'h31323334;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_a, cmd_b;
    logic [3:0] cmd_op;
    logic       res_valid, res_parity_err, res_timeout, authed;
    logic [7:0] res_data, tx_data, rx_data;
    logic       tx_start, tx_busy, rx_valid, rx_parity_error;
    logic       busy_model, busy_hold;

    assign tx_busy = busy_model | busy_hold;

    alu_link_master #(.PASSWORD(PW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .res_valid(res_valid), .res_data(res_data),
        .res_parity_err(res_parity_err), .res_timeout(res_timeout),
        .authed(authed),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_error(rx_parity_error)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] byte_q[$];
    logic       auth_q[$];
    logic [7:0] exp_q[$];
    bit         model_authed = 1'b0;
    logic [7:0] last_res = 8'h00;
    bit         prev_start = 1'b0;
    bit         pend = 1'b0;
    int         bcnt = 0;

    // uart_tx model: busy rises one cycle after start and stays high 10 cycles.
    initial busy_model = 1'b0;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            busy_model = 1'b0; pend = 1'b0; bcnt = 0;
        end else begin
            if (pend) begin
                busy_model = 1'b1; bcnt = 10; pend = 1'b0;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) busy_model = 1'b0;
            end
            if (tx_start === 1'b1) pend = 1'b1;
        end
    end

    // Byte monitor plus always-on protocol properties.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            byte_q.push_back(tx_data);
            auth_q.push_back(authed);
            n_checks++;
            if (prev_start) begin
                n_fail++;
                $display("FAIL start_spacing: tx_start high in consecutive cycles at %0t", $time);
            end
        end
        prev_start = (tx_start === 1'b1);
        if (res_valid === 1'b1 || res_timeout === 1'b1) begin
            n_checks++;
            if (res_valid === 1'b1 && res_timeout === 1'b1) begin
                n_fail++;
                $display("FAIL res_exclusive: res_valid=1 res_timeout=1, required not both");
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0; rx_valid = 1'b0; rx_parity_error = 1'b0;
        rx_data = 8'h00; busy_hold = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        model_authed = 1'b0; last_res = 8'h00;
        byte_q.delete(); auth_q.delete();
    endtask

    // Expected wire bytes from the protocol rules; password only while not yet authenticated.
    task automatic build_exp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        exp_q.delete();
        if (!model_authed) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(8'(PW >> (24 - 8 * i)));
        end
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back({4'h0, op});
        model_authed = 1'b1;
        byte_q.delete(); auth_q.delete();
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        for (int i = 0; i < 200 && cmd_ready !== 1'b1; i++) tick();
        if (cmd_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_accept: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 3000 && byte_q.size() < n; i++) tick();
        if (byte_q.size() < n) begin
            n_checks++; n_fail++;
            $display("FAIL byte_wait: got %0d bytes, required %0d", byte_q.size(), n);
        end
    endtask

    // Returns at the negedge where busy falls after the last byte.
    task automatic wait_bus_done();
        int i;
        for (i = 0; i < 50 && tx_busy !== 1'b1; i++) tick();
        for (i = 0; i < 50 && tx_busy !== 1'b0; i++) tick();
        if (tx_busy !== 1'b0) begin
            n_checks++; n_fail++;
            $display("FAIL busy_wait: tx_busy=%b, required 0", tx_busy);
        end
    endtask

    task automatic pulse_rx(input logic [7:0] d, input logic par);
        rx_data = d; rx_parity_error = par; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0; rx_parity_error = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 8;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b, required 1", cmd_ready); end
        if (authed !== 1'b0) begin n_fail++; $display("FAIL rst_authed: got %b, required 0", authed); end
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b, required 0", res_valid); end
        if (res_data !== 8'h00) begin n_fail++; $display("FAIL rst_res_data: got %h, required 00", res_data); end
        if (res_parity_err !== 1'b0) begin n_fail++; $display("FAIL rst_parity: got %b, required 0", res_parity_err); end
        if (res_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b, required 0", res_timeout); end
        if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b, required 0", tx_start); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
    endtask

    task automatic test_first_cmd();
        build_exp(8'h05, 8'h03, 4'h0);
        send_cmd(8'h05, 8'h03, 4'h0);
        n_checks++;
        if (tx_start !== 1'b0) begin n_fail++; $display("FAIL first_start_early: tx_start=%b, required 0", tx_start); end
        tick();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h31) begin
            n_fail++; $display("FAIL first_start_latency: tx_start=%b tx_data=%h, required 1/31", tx_start, tx_data);
        end
        wait_bytes(7);
        wait_bus_done();
        n_checks++;
        if (byte_q.size() != 7) begin n_fail++; $display("FAIL first_count: got %0d bytes, required 7", byte_q.size()); end
        for (int i = 0; i < 7 && i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL first_byte%0d: got %h, required %h", i, byte_q[i], exp_q[i]); end
        end
        if (auth_q.size() >= 5) begin
            n_checks++;
            if (auth_q[3] !== 1'b0 || auth_q[4] !== 1'b1) begin
                n_fail++; $display("FAIL first_authed: at byte4=%b byte5=%b, required 0/1", auth_q[3], auth_q[4]);
            end
        end
        tick();
        pulse_rx(8'h08, 1'b0);
        last_res = 8'h08;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h08 || cmd_ready !== 1'b1 || res_timeout !== 1'b0) begin
            n_fail++; $display("FAIL first_result: valid=%b data=%h ready=%b to=%b, required 1/08/1/0", res_valid, res_data, cmd_ready, res_timeout);
        end
        tick();
        n_checks++;
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL first_res_pulse: res_valid=%b, required 0", res_valid); end
    endtask

    task automatic test_second_cmd();
        build_exp(8'hF0, 8'h0F, 4'h2);
        send_cmd(8'hF0, 8'h0F, 4'h2);
        wait_bytes(3);
        wait_bus_done();
        n_checks++;
        if (byte_q.size() != 3) begin n_fail++; $display("FAIL second_count: got %0d bytes, required 3", byte_q.size()); end
        for (int i = 0; i < 3 && i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL second_byte%0d: got %h, required %h", i, byte_q[i], exp_q[i]); end
        end
        repeat (2) tick();
        pulse_rx(8'h00, 1'b0);
        last_res = 8'h00;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h00 || res_parity_err !== 1'b0) begin
            n_fail++; $display("FAIL second_result: valid=%b data=%h par=%b, required 1/00/0", res_valid, res_data, res_parity_err);
        end
        tick();
    endtask

    task automatic test_busy_backpressure();
        logic [7:0] r;
        do_reset();
        busy_hold = 1'b1;
        build_exp(8'h12, 8'h34, 4'h1);
        send_cmd(8'h12, 8'h34, 4'h1);
        repeat (50) tick();
        n_checks++;
        if (byte_q.size() != 0) begin n_fail++; $display("FAIL bp_hold: got %0d starts while busy, required 0", byte_q.size()); end
        busy_hold = 1'b0;
        wait_bytes(7);
        wait_bus_done();
        n_checks++;
        if (byte_q.size() != 7) begin n_fail++; $display("FAIL bp_count: got %0d bytes, required 7", byte_q.size()); end
        for (int i = 0; i < 7 && i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h, required %h", i, byte_q[i], exp_q[i]); end
        end
        tick();
        r = 8'($urandom);
        pulse_rx(r, 1'b0);
        last_res = r;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== r) begin
            n_fail++; $display("FAIL bp_result: valid=%b data=%h, required 1/%h", res_valid, res_data, r);
        end
        tick();
    endtask

    task automatic test_timeout();
        build_exp(8'h77, 8'h66, 4'h3);
        send_cmd(8'h77, 8'h66, 4'h3);
        wait_bytes(3);
        wait_bus_done();
`ifdef ALU_LINK_MASTER_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            tick();
            n_checks++;
            if (res_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early: res_timeout=%b at cycle %0d, required 0", res_timeout, k); end
        end
        tick();
        n_checks += 5;
        if (res_timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse: res_timeout=%b, required 1", res_timeout); end
        if (res_valid !== 1'b0) begin n_fail++; $display("FAIL to_valid: res_valid=%b, required 0", res_valid); end
        if (authed !== 1'b1) begin n_fail++; $display("FAIL to_authed: authed=%b, required 1", authed); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: cmd_ready=%b, required 1", cmd_ready); end
        if (res_data !== last_res) begin n_fail++; $display("FAIL to_data: res_data=%h, required %h", res_data, last_res); end
        tick();
        n_checks++;
        if (res_timeout !== 1'b0) begin n_fail++; $display("FAIL to_width: res_timeout=%b, required 0", res_timeout); end
`else
        for (int k = 1; k <= 3 * TO; k++) begin
            tick();
            n_checks++;
            if (res_timeout !== 1'b0 || cmd_ready !== 1'b0) begin
                n_fail++; $display("FAIL nto_wait: to=%b ready=%b, required 0/0", res_timeout, cmd_ready);
            end
        end
        pulse_rx(8'h3C, 1'b0);
        last_res = 8'h3C;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h3C) begin n_fail++; $display("FAIL nto_result: valid=%b data=%h, required 1/3c", res_valid, res_data); end
`endif
        tick();
    endtask

    task automatic test_stray_late();
        build_exp(8'hA1, 8'hB2, 4'h4);
        send_cmd(8'hA1, 8'hB2, 4'h4);
        wait_bytes(1);
        pulse_rx(8'hAA, 1'b0);
        n_checks++;
        if (res_valid !== 1'b0 || res_data !== last_res) begin
            n_fail++; $display("FAIL stray_ignored: valid=%b data=%h, required 0/%h", res_valid, res_data, last_res);
        end
        wait_bytes(3);
        wait_bus_done();
`ifdef ALU_LINK_MASTER_TIMEOUT_EN
        // Land the reply in the cycle where the counter reaches its last value.
        for (int k = 1; k <= TO; k++) begin
            tick();
            n_checks++;
            if (res_timeout !== 1'b0) begin n_fail++; $display("FAIL late_early_to: res_timeout=%b, required 0", res_timeout); end
        end
`else
        repeat (TO) tick();
`endif
        pulse_rx(8'h55, 1'b1);
        last_res = 8'h55;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 8'h55 || res_parity_err !== 1'b1 || res_timeout !== 1'b0) begin
            n_fail++; $display("FAIL late_result: valid=%b data=%h par=%b to=%b, required 1/55/1/0", res_valid, res_data, res_parity_err, res_timeout);
        end
        tick();
        n_checks++;
        if (res_timeout !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL late_after: to=%b valid=%b, required 0/0", res_timeout, res_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, r;
        logic [3:0] op;
        logic       par;
        int         n;
        for (int t = 0; t < 8; t++) begin
            a = 8'($urandom); b = 8'($urandom); op = 4'($urandom); r = 8'($urandom);
            par = 1'($urandom_range(0, 1));
            build_exp(a, b, op);
            n = exp_q.size();
            send_cmd(a, b, op);
            wait_bytes(n);
            wait_bus_done();
            n_checks++;
            if (byte_q.size() != n) begin n_fail++; $display("FAIL rnd%0d_count: got %0d, required %0d", t, byte_q.size(), n); end
            for (int i = 0; i < n && i < byte_q.size(); i++) begin
                n_checks++;
                if (byte_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_byte%0d: got %h, required %h", t, i, byte_q[i], exp_q[i]); end
            end
            repeat ($urandom_range(1, 8)) tick();
            pulse_rx(r, par);
            last_res = r;
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== r || res_parity_err !== par) begin
                n_fail++; $display("FAIL rnd%0d_result: valid=%b data=%h par=%b, required 1/%h/%b", t, res_valid, res_data, res_parity_err, r, par);
            end
            $display("txn %0d: a=%h b=%h op=%h bytes=%0d result=%h par=%b", t, a, b, op, n, r, par);
            tick();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        build_exp(8'h21, 8'h43, 4'h5);
        send_cmd(8'h21, 8'h43, 4'h5);
        wait_bytes(2);
        reset = 1'b1;
        repeat (2) begin
            tick();
            n_checks++;
            if (tx_start !== 1'b0 || authed !== 1'b0) begin
                n_fail++; $display("FAIL mrst_abort: tx_start=%b authed=%b, required 0/0", tx_start, authed);
            end
        end
        reset = 1'b0;
        model_authed = 1'b0;
        byte_q.delete(); auth_q.delete();
        repeat (20) tick();
        n_checks++;
        if (byte_q.size() != 0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL mrst_quiet: starts=%0d ready=%b, required 0/1", byte_q.size(), cmd_ready);
        end
        build_exp(8'h9A, 8'hBC, 4'h6);
        send_cmd(8'h9A, 8'hBC, 4'h6);
        wait_bytes(7);
        wait_bus_done();
        n_checks++;
        if (byte_q.size() != 7) begin n_fail++; $display("FAIL mrst_count: got %0d bytes, required 7", byte_q.size()); end
        for (int i = 0; i < 7 && i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mrst_byte%0d: got %h, required %h", i, byte_q[i], exp_q[i]); end
        end
        tick();
        pulse_rx(8'hE7, 1'b0);
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 8'hE7 || authed !== 1'b1) begin
            n_fail++; $display("FAIL mrst_result: valid=%b data=%h authed=%b, required 1/e7/1", res_valid, res_data, authed);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 4'h0;
        rx_valid = 1'b0; rx_data = 8'h00; rx_parity_error = 1'b0; busy_hold = 1'b0;
        test_reset();
        test_first_cmd();
        test_second_cmd();
        test_busy_backpressure();
        test_timeout();
        test_stray_late();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
